// File: rtl/ov7670_emulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ov7670_emulator                                                            |
// | Replays a frame buffer as an OV7670 pclk/href/vsync/data byte stream        |
// | (RGB444 or YUV422 gray). Optional build macro: OV7670_EMU_TESTPAT_EN adds   |
// | a 'testpat' input that replaces buffer pixels with a col/row pattern.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ov7670_emulator #(
  parameter int c_img_cols     = 80,
  parameter int c_img_rows     = 60,
  parameter int c_nb_line_pxls = 7,
  parameter int c_nb_img_pxls  = 13,
  parameter int c_nb_buf       = 12,
  parameter int c_pclk_div     = 4,
  parameter int c_vsync_bytes  = 16,
  parameter int c_vbp_bytes    = 32,
  parameter int c_hblank_bytes = 20,
  parameter int c_vfp_bytes    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     rgbmode,
  input  logic                     swap_r_b,
`ifdef OV7670_EMU_TESTPAT_EN
  input  logic                     testpat,
`endif
  output logic [c_nb_img_pxls-1:0] addr,
  input  logic [c_nb_buf-1:0]      din,
  output logic                     pclk,
  output logic                     href,
  output logic                     vsync,
  output logic [7:0]               data,
  output logic                     frame_done
);

  localparam int c_nb_div  = $clog2(c_pclk_div);
  localparam int c_bsum    = 2*c_img_cols + c_vsync_bytes + c_vbp_bytes + c_hblank_bytes + c_vfp_bytes;
  localparam int c_nb_bmin = (c_nb_line_pxls + 1 > 5) ? c_nb_line_pxls + 1 : 5;
  localparam int c_nb_bcnt = ($clog2(c_bsum) > c_nb_bmin) ? $clog2(c_bsum) : c_nb_bmin;
  localparam int c_nb_row  = ($clog2(c_img_rows) > 4) ? $clog2(c_img_rows) : 4;

  localparam logic [c_nb_div-1:0]      c_div_last    = c_nb_div'(c_pclk_div - 1);
  localparam logic [c_nb_div-1:0]      c_div_half    = c_nb_div'(c_pclk_div / 2);
  localparam logic [c_nb_bcnt-1:0]     c_vsync_last  = c_nb_bcnt'(c_vsync_bytes - 1);
  localparam logic [c_nb_bcnt-1:0]     c_vbp_last    = c_nb_bcnt'(c_vbp_bytes - 1);
  localparam logic [c_nb_bcnt-1:0]     c_active_last = c_nb_bcnt'(2*c_img_cols - 1);
  localparam logic [c_nb_bcnt-1:0]     c_hblank_last = c_nb_bcnt'(c_hblank_bytes - 1);
  localparam logic [c_nb_bcnt-1:0]     c_vfp_last    = c_nb_bcnt'(c_vfp_bytes - 1);
  localparam logic [c_nb_row-1:0]      c_row_last    = c_nb_row'(c_img_rows - 1);
  localparam logic [c_nb_img_pxls-1:0] c_addr_last   = c_nb_img_pxls'(c_img_cols*c_img_rows - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBP    = 3'd2,
    S_ACTIVE = 3'd3,
    S_HBLANK = 3'd4,
    S_VFP    = 3'd5
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [c_nb_div-1:0]      r_cnt_div, w_cnt_nxt;
  logic [c_nb_bcnt-1:0]     r_bcnt, w_bcnt_nxt;
  logic [c_nb_row-1:0]      r_row, w_row_nxt;
  logic [c_nb_img_pxls-1:0] r_addr;
  logic [c_nb_buf-1:0]      r_pix, w_word;
  logic [7:0]               r_data, w_data_nxt;
  logic                     r_pclk, r_href, r_vsync, r_frame_done;
  logic                     r_rgb, r_swap, w_tp;
  logic                     w_tick, w_start, w_frame_end, w_href_nxt, w_vsync_nxt, w_load;

  assign w_tick    = (r_cnt_div == c_div_last);
  assign w_cnt_nxt = w_tick ? '0 : r_cnt_div + 1'b1;

`ifdef OV7670_EMU_TESTPAT_EN
  logic r_tp;
  always_ff @(posedge clk) begin
    if (rst)
      r_tp <= 1'b0;
    else if (w_tick && w_start)
      r_tp <= testpat;
  end
  assign w_tp = r_tp;
`else
  assign w_tp = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt + 1'b1;
    w_row_nxt   = r_row;
    w_start     = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_bcnt_nxt = '0;
        if (enable) begin
          w_state_nxt = S_VSYNC;
          w_start     = 1'b1;
        end
      end
      S_VSYNC: if (r_bcnt == c_vsync_last) begin
        w_state_nxt = S_VBP;
        w_bcnt_nxt  = '0;
      end
      S_VBP: if (r_bcnt == c_vbp_last) begin
        w_state_nxt = S_ACTIVE;
        w_bcnt_nxt  = '0;
      end
      S_ACTIVE: if (r_bcnt == c_active_last) begin
        w_state_nxt = S_HBLANK;
        w_bcnt_nxt  = '0;
      end
      S_HBLANK: if (r_bcnt == c_hblank_last) begin
        w_bcnt_nxt = '0;
        if (r_row == c_row_last) begin
          w_state_nxt = S_VFP;
        end else begin
          w_state_nxt = S_ACTIVE;
          w_row_nxt   = r_row + 1'b1;
        end
      end
      S_VFP: if (r_bcnt == c_vfp_last) begin
        w_bcnt_nxt  = '0;
        w_frame_end = 1'b1;
        if (enable) begin
          w_state_nxt = S_VSYNC;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_bcnt_nxt  = '0;
      end
    endcase
    if (w_start)
      w_row_nxt = '0;

    // Outputs are computed for the byte period that starts after this tick.
    w_href_nxt  = (w_state_nxt == S_ACTIVE);
    w_vsync_nxt = (w_state_nxt == S_VSYNC);
    w_load      = w_href_nxt && !w_bcnt_nxt[0];
    w_word      = w_tp ? {w_bcnt_nxt[4:1], w_row_nxt[3:0], 4'h5} : din;

    w_data_nxt = 8'h00;
    if (w_href_nxt) begin
      if (!w_bcnt_nxt[0]) begin
        if (r_rgb)
          w_data_nxt = r_swap ? {4'h0, w_word[3:0]} : {4'h0, w_word[11:8]};
        else
          w_data_nxt = w_tp ? w_word[11:4] : w_word[7:0];
      end else begin
        if (r_rgb)
          w_data_nxt = r_swap ? {r_pix[7:4], r_pix[11:8]} : r_pix[7:0];
        else
          w_data_nxt = 8'h80;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_div    <= '0;
      r_pclk       <= 1'b0;
      r_state      <= S_IDLE;
      r_bcnt       <= '0;
      r_row        <= '0;
      r_href       <= 1'b0;
      r_vsync      <= 1'b0;
      r_data       <= 8'h00;
      r_frame_done <= 1'b0;
      r_addr       <= '0;
      r_pix        <= '0;
      r_rgb        <= 1'b0;
      r_swap       <= 1'b0;
    end else begin
      r_cnt_div    <= w_cnt_nxt;
      r_pclk       <= (w_cnt_nxt >= c_div_half);
      r_frame_done <= 1'b0;
      if (w_tick) begin
        r_state      <= w_state_nxt;
        r_bcnt       <= w_bcnt_nxt;
        r_row        <= w_row_nxt;
        r_href       <= w_href_nxt;
        r_vsync      <= w_vsync_nxt;
        r_data       <= w_data_nxt;
        r_frame_done <= w_frame_end;
        if (w_start) begin
          r_rgb  <= rgbmode;
          r_swap <= swap_r_b;
          r_addr <= '0;
        end else if (w_load) begin
          // Holding the last address keeps the read in range through VFP.
          r_pix <= w_word;
          if (r_addr != c_addr_last)
            r_addr <= r_addr + 1'b1;
        end
      end
    end
  end

  assign addr       = r_addr;
  assign pclk       = r_pclk;
  assign href       = r_href;
  assign vsync      = r_vsync;
  assign data       = r_data;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_emulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ov7670_emulator                                                         |
// | Captures the emitted byte stream and checks it against a pixel-level model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ov7670_emulator;

  localparam int P_COLS = 8;
  localparam int P_ROWS = 6;
  localparam int P_DIV  = 4;
  localparam int P_VS   = 16;
  localparam int P_VBP  = 32;
  localparam int P_HB   = 20;
  localparam int P_VFP  = 32;
  localparam int NPIX   = P_COLS * P_ROWS;
  localparam int FRAME_CLKS = (P_VS + P_VBP + P_ROWS*(2*P_COLS + P_HB) + P_VFP) * P_DIV;

  logic        clk = 1'b0;
  logic        rst, enable, rgbmode, swap_r_b;
  logic [12:0] addr;
  logic [11:0] din;
  logic        pclk, href, vsync, frame_done;
  logic [7:0]  data;
`ifdef OV7670_EMU_TESTPAT_EN
  logic        testpat;
`endif

  ov7670_emulator #(
    .c_img_cols(P_COLS), .c_img_rows(P_ROWS), .c_nb_line_pxls(7), .c_nb_img_pxls(13),
    .c_nb_buf(12), .c_pclk_div(P_DIV), .c_vsync_bytes(P_VS), .c_vbp_bytes(P_VBP),
    .c_hblank_bytes(P_HB), .c_vfp_bytes(P_VFP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .rgbmode(rgbmode), .swap_r_b(swap_r_b),
`ifdef OV7670_EMU_TESTPAT_EN
    .testpat(testpat),
`endif
    .addr(addr), .din(din), .pclk(pclk), .href(href), .vsync(vsync),
    .data(data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [NPIX];
  always @(posedge clk) din <= (int'(addr) < NPIX) ? mem[addr] : 12'h000;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pixel-level model of the byte stream for a whole frame.
  function automatic logic [7:0] model_byte(input int k, input bit rgb, input bit sw, input bit tp);
    int p;
    logic [11:0] w;
    logic [3:0]  c4, r4;
    p  = k / 2;
    c4 = 4'(p % P_COLS);
    r4 = 4'(p / P_COLS);
    w  = tp ? {c4, r4, 4'h5} : mem[p];
    if (rgb) begin
      if (k % 2 == 0) return {4'h0, (sw ? w[3:0] : w[11:8])};
      return sw ? {w[7:4], w[11:8]} : w[7:0];
    end
    if (k % 2 == 0) return tp ? w[11:4] : w[7:0];
    return 8'h80;
  endfunction

  logic [7:0] cap[$];
  int  cyc = 0, vs_run = 0, vs_len = 0, gap = 0, gap_run = 0;
  int  href_run = 0, href_min = 0, href_max = 0, href_cnt = 0;
  int  fd_cnt = 0, fd_last = -1, fd_period = 0;
  bit  gap_on = 1'b0, p_vs = 1'b0, p_href = 1'b0, p_pclk = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      p_vs = 1'b0; p_href = 1'b0; p_pclk = 1'b0; gap_on = 1'b0; href_run = 0;
    end else begin
      if (vsync && !p_vs) begin
        cap.delete(); vs_run = 0; href_cnt = 0; href_min = 1 << 30; href_max = 0;
      end
      if (vsync) vs_run++;
      if (p_vs && !vsync) begin vs_len = vs_run; gap_on = 1'b1; gap_run = 0; end
      if (gap_on) begin
        if (href) begin gap = gap_run; gap_on = 1'b0; end
        else gap_run++;
      end
      if (href) href_run++;
      if (p_href && !href) begin
        href_cnt++;
        if (href_run < href_min) href_min = href_run;
        if (href_run > href_max) href_max = href_run;
        href_run = 0;
      end
      if (pclk && !p_pclk && href) cap.push_back(data);
      if (frame_done) begin
        fd_cnt++;
        if (fd_last >= 0) fd_period = cyc - fd_last;
        fd_last = cyc;
      end
      p_vs = vsync; p_href = href; p_pclk = pclk;
    end
  end

  task automatic wait_vs(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 2*FRAME_CLKS) begin @(negedge clk); n++; ok = vsync; end
  endtask

  task automatic wait_fd(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 2*FRAME_CLKS) begin @(negedge clk); n++; ok = frame_done; end
    #1;
  endtask

  typedef struct {
    bit          rgb;
    bit          sw;
    bit          tp;
    int          pix;
    logic [11:0] word;
    logic [7:0]  e0;
    logic [7:0]  e1;
  } vec_t;

  vec_t vecs[$];

  // One frame; with 'two' the next frame runs with the modes flipped mid-frame.
  task automatic run_vec(input vec_t v, input bit two);
    bit ok, rgb_l, sw_l, tp_l, bad;
    int fd0;
    if (v.pix >= 0) mem[v.pix] = v.word;
    rgbmode = v.rgb; swap_r_b = v.sw;
    rgb_l = v.rgb; sw_l = v.sw; tp_l = 1'b0;
`ifdef OV7670_EMU_TESTPAT_EN
    testpat = v.tp; tp_l = v.tp;
`endif
    fd0 = fd_cnt;
    enable = 1'b1;
    wait_vs(ok);
    check("vsync_start", 32'(ok), 32'd1);
    rgbmode = ~v.rgb; swap_r_b = ~v.sw;
    if (two) begin
      wait_fd(ok);
      check("frame_done_1", 32'(ok), 32'd1);
      rgb_l = ~v.rgb; sw_l = ~v.sw;
    end
    enable = 1'b0;
    wait_fd(ok);
    check("frame_done", 32'(ok), 32'd1);
    check("fd_pulses", 32'(fd_cnt - fd0), two ? 32'd2 : 32'd1);
    if (two) check("frame_period", 32'(fd_period), 32'(FRAME_CLKS));
    check("vsync_len", 32'(vs_len), 32'(P_VS*P_DIV));
    check("vbp_gap", 32'(gap), 32'(P_VBP*P_DIV));
    check("href_count", 32'(href_cnt), 32'(P_ROWS));
    check("href_min", 32'(href_min), 32'(2*P_COLS*P_DIV));
    check("href_max", 32'(href_max), 32'(2*P_COLS*P_DIV));
    check("byte_count", 32'(cap.size()), 32'(2*NPIX));
    if (cap.size() == 2*NPIX) begin
      for (int k = 0; k < 2*NPIX; k++)
        check($sformatf("byte[%0d]", k), 32'(cap[k]), 32'(model_byte(k, rgb_l, sw_l, tp_l)));
      if (v.pix >= 0 && !two) begin
        check("tbl_byte0", 32'(cap[2*v.pix]), 32'(v.e0));
        check("tbl_byte1", 32'(cap[2*v.pix+1]), 32'(v.e1));
      end
    end
    bad = 1'b0;
    repeat (3*FRAME_CLKS/20) begin
      @(negedge clk);
      if (href || vsync || frame_done || data != 8'h00) bad = 1'b1;
    end
    check("idle_low", 32'(bad), 32'd0);
  endtask

  initial begin
    bit   ok;
    vec_t rv;
    rst = 1'b1; enable = 1'b0; rgbmode = 1'b0; swap_r_b = 1'b0;
`ifdef OV7670_EMU_TESTPAT_EN
    testpat = 1'b0;
`endif
    for (int i = 0; i < NPIX; i++) mem[i] = 12'($urandom);
    repeat (5) @(negedge clk);
    check("rst_pclk", 32'(pclk), 32'd0);
    check("rst_href", 32'(href), 32'd0);
    check("rst_vsync", 32'(vsync), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    vecs.push_back('{1'b1, 1'b0, 1'b0, 0,  12'hABC, 8'h0A, 8'hBC});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 0,  12'hABC, 8'h0C, 8'hBA});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 5,  12'h037, 8'h37, 8'h80});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 5,  12'h037, 8'h37, 8'h80});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 47, 12'hF3E, 8'h0F, 8'h3E});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 47, 12'hF3E, 8'h0E, 8'h3F});
`ifdef OV7670_EMU_TESTPAT_EN
    vecs.push_back('{1'b1, 1'b0, 1'b1, 2*P_COLS+3, 12'hFFF, 8'h03, 8'h25});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2*P_COLS+3, 12'hFFF, 8'h32, 8'h80});
`endif
    foreach (vecs[i]) run_vec(vecs[i], 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NPIX; i++) mem[i] = 12'($urandom);
      rv = '{bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0, -1, 12'h000, 8'h00, 8'h00};
      run_vec(rv, r == 2);
    end

    // Reset in the middle of a line clears every output on the next edge.
    enable = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 2*FRAME_CLKS && !ok; n++) begin @(negedge clk); ok = href; end
    check("href_seen", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    check("mid_rst_pclk", 32'(pclk), 32'd0);
    check("mid_rst_href", 32'(href), 32'd0);
    check("mid_rst_vsync", 32'(vsync), 32'd0);
    check("mid_rst_data", 32'(data), 32'd0);
    check("mid_rst_addr", 32'(addr), 32'd0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("post_rst_idle", 32'({vsync, href, frame_done}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ov7670_emulator.md
# ov7670_emulator

Synthesizable OV7670 camera-side stream generator: reads pixels from a frame buffer and drives the same pclk/href/vsync/data[7:0] parallel interface a real OV7670 produces (two bytes per pixel, RGB444 or YUV422). It is the transmitting end of the camera capture path: it feeds the capture block in closed-loop self-test, and lets the vision pipeline run on stored images without a sensor attached. It sits between a dual-port frame buffer (read side) and the camera input pins, or the capture block's inputs.

## Interface
- c_img_cols, 80, pixels per line
- c_img_rows, 60, lines per frame
- c_nb_line_pxls, 7, width of column counter
- c_nb_img_pxls, 13, buffer address width
- c_nb_buf, 12, buffer word width; RGB444 is {red[11:8], green[7:4], blue[3:0]}, gray is [7:0]
- c_pclk_div, 4, clk cycles per pclk period; even, ≥4
- c_vsync_bytes, 16, pclk periods with vsync high
- c_vbp_bytes, 32, pclk periods from vsync fall to first href
- c_hblank_bytes, 20, pclk periods with href low between lines
- c_vfp_bytes, 32, pclk periods after the last line before the next vsync

Ports:
- clk  in  1  FPGA clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- enable  in  1  run frames continuously while high
- rgbmode  in  1  1: RGB444, 0: YUV422 (gray)
- swap_r_b  in  1  swap red and blue byte positions
- addr  out  c_nb_img_pxls  buffer read address
- din  in  c_nb_buf  buffer read data, one-clk latency after addr
- pclk  out  1  generated byte clock
- href  out  1  line valid
- vsync  out  1  frame sync, active high
- data  out  8  pixel byte
- frame_done  out  1  one-clk pulse at end of each frame

## Operation
- Divider cnt_div counts 0..c_pclk_div-1 continuously after reset, in every state; pclk = 0 for cnt_div < c_pclk_div/2, 1 otherwise. Byte tick = cycle with cnt_div == c_pclk_div-1.
- href, vsync, data, state and byte counters update only on byte ticks; they change with pclk falling and are stable c_pclk_div/2 clks before pclk rising.
- FSM states: IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP.
  - IDLE: outputs low, data 0. On a tick with enable=1 -> VSYNC; latch rgbmode/swap_r_b; addr <= 0.
  - VSYNC: vsync=1 for c_vsync_bytes ticks -> VBP.
  - VBP: c_vbp_bytes ticks -> ACTIVE.
  - ACTIVE: href=1 for 2*c_img_cols ticks -> HBLANK.
  - HBLANK: c_hblank_bytes ticks; -> ACTIVE if row < c_img_rows-1, else -> VFP.
  - VFP: c_vfp_bytes ticks; frame_done=1 on the final tick; then -> VSYNC if enable, else IDLE.
- Byte order per pixel: RGB, swap=0: byte0 = {4'h0, red}, byte1 = {green, blue}. RGB, swap=1: byte0 = {4'h0, blue}, byte1 = {green, red}. YUV: byte0 = din[7:0] (Y), byte1 = 8'h80 (neutral chroma).
- Prefetch: pix_rg <= din on every tick whose next byte is byte0 of a pixel, including the last VBP/HBLANK tick; addr increments on the same tick. addr therefore always holds the next pixel, is stable ≥2 byte periods before use, and tolerates the 1-clk read latency.
- addr counts 0..c_img_cols*c_img_rows-1 linearly; it does not wrap within a frame and is reloaded with 0 on VSYNC entry.

## Timing
- Reset: pclk, href, vsync, data, frame_done, addr, cnt_div = 0; state IDLE. Reset mid-frame aborts the frame at the next edge; there is no partial-frame completion.
- First vsync rises ≤ c_pclk_div clks after enable is sampled high on a tick.
- Defaults: line = 160 active + 20 blank bytes; frame = 16+32+60*180+32 = 10880 pclk = 43520 clk.
- enable falling mid-frame: the frame completes, then IDLE. rgbmode/swap_r_b changes mid-frame are ignored until the next VSYNC entry.
- vsync high lasts c_vsync_bytes*c_pclk_div ≥ 4 clks, which satisfies a glitch-filtered receiver.

## Configuration
- OV7670_EMU_TESTPAT_EN: when defined, adds input testpat (1 bit, latched at VSYNC entry). With testpat=1, din is ignored and pixel = {col[3:0], row[3:0], 4'h5}; in YUV mode Y = {col[3:0], row[3:0]}. When undefined, the port is absent and pixels always come from din.

## Test plan
- Reset, then enable=1 with defaults -> vsync high for exactly 64 clks, the first href rises 128 clks later, each href lasts 640 clks, and 60 hrefs occur per frame.
- RGB, swap=0, buffer[0]=12'hABC -> first two bytes of line 0 are 8'h0A then 8'hBC; with swap=1, 8'h0C then 8'hBA.
- YUV, buffer[5]=12'h037 -> pixel 5 bytes are 8'h37, 8'h80.
- Loopback into the capture block with default geometry -> capture writes addresses 0..4799 once per frame with data equal to buffer contents; frame_done pulses once per 43520 clks.
- enable dropped in the middle of row 30 -> rows 30..59 and VFP still complete, frame_done pulses, then outputs stay low; rst asserted mid-line -> all outputs 0 on the next clk.
- With OV7670_EMU_TESTPAT_EN defined and testpat=1 -> pixel (col=3, row=2) gives bytes 8'h03, 8'h25.
